ekf_pwm_dac: RTL and testbench
==============================

Name: ekf_pwm_dac

Overview:
- Four-channel PWM "DAC" output stage, downstream of the EKF core and status/fault logic.
- Takes the Q16.16 SOC/SOH estimates and the 8-bit fault code and produces glitch-free 10-bit PWM waveforms for external RC filters.
- Also produces a free-running heartbeat square wave.
- Channel order is 0 = SOC, 1 = SOH, 2 = FAULT, 3 = HEARTBEAT.

Parameters:
- CLK_FREQ, 20_000_000, system clock in Hz.
- PWM_FREQ, 20_000, PWM carrier frequency in Hz. PERIOD = CLK_FREQ/PWM_FREQ cycles (1000 at default); must be ≥ 2.
- PWM_RES, 10, duty code width in bits.
- HEARTBEAT_HZ, 1, heartbeat frequency. HB_HALF = CLK_FREQ/(2*HEARTBEAT_HZ) cycles.
- DATA_WIDTH, 32, input word width.
- FRAC_BITS, 16, fractional bits of inputs.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- upd_valid  in  1  single-cycle strobe: capture soc_in/soh_in/fault_in/mode_in into shadow registers
- soc_in  in  DATA_WIDTH  signed Q16.16 SOC, 1.0 = 0x0001_0000
- soh_in  in  DATA_WIDTH  signed Q16.16 SOH
- fault_in  in  8  fault code, 0x00 = none
- mode_in  in  2  00 normal, 01 off, 10 test, 11 = off
- pwm_out  out  4  PWM outputs, bit index = channel
- period_start  out  1  one-cycle pulse when the PWM counter is 0
- upd_ack  out  1  one-cycle pulse, the cycle after upd_valid

Behaviour:
- Reset (async assert, sync-released use):
  - pwm_out = 0, period_start = 0, upd_ack = 0.
  - Period counter = 0, heartbeat counter = 0, heartbeat level = 0.
  - All shadow and active registers = 0; shadow mode = 00.
- Period counter:
  - Counts 0..PERIOD-1 and wraps.
  - period_start is registered and is high exactly when the counter value is 0.
- Duty conversion, done when the shadow registers are written:
  - Value < 0 → 0.
  - Value ≥ 0x0001_0000 → 1023.
  - Otherwise → value[FRAC_BITS-1:FRAC_BITS-PWM_RES], i.e. bits [15:6].
  - FAULT channel code = {fault_in, 2'b00}.
- Mode override applied to channels 0–2:
  - 01/11 forces code 0.
  - 10 forces code 512.
  - 00 passes the converted codes.
- Threshold: thr = (code*PERIOD) >> PWM_RES, computed with a ≥ PWM_RES+$clog2(PERIOD)+1-bit product and no truncation before the shift.
- Double-buffering:
  - Active thresholds load from the shadow registers when the counter = PERIOD-1, so new duty takes effect on the next counter = 0.
  - Thresholds are never changed mid-period; there is no runt pulse.
- Output: pwm_out[ch] = registered (counter < thr_active[ch]) for ch 0–2. thr = 0 → constant low.
- upd_valid on the same cycle as the PERIOD-1 load: the active registers take the old shadow content, and the new values apply one period later.
- Back-to-back upd_valid: last write wins; upd_ack pulses for each strobe.
- Heartbeat:
  - Counter counts 0..HB_HALF-1; level toggles at wrap.
  - pwm_out[3] = level.
  - In modes 01/11, pwm_out[3] = 0, but the counter keeps running.
- Output latency: one register stage from counter value to pwm_out. All outputs are registered.

Test Plan:
- Reset mid-operation (rst_n low for 3 cycles during high phase) → pwm_out = 0 immediately (async); counters restart; first period_start 1 cycle after release. Use CLK_FREQ=20_000, PWM_FREQ=20, HEARTBEAT_HZ=1 (PERIOD = 1000) for every scenario.
- soc_in = 0x0000_8000, mode 00 → code 512, 500 high cycles per 1000-cycle period, starting at the period boundary after the load.
- soc_in = 0x0001_0000 → 999 high cycles. soc_in = 0xFFFF_0000 → pwm_out[0] constantly low. soh_in = 0x0002_0000 → saturated, 999 high cycles.
- fault_in = 0x20 → code 128, 125 high cycles on pwm_out[2]. mode_in = 10 → channels 0–2 each 500 high cycles. mode_in = 01 → pwm_out = 0000.
- upd_valid asserted at counter = 300 with new SOC → current period unchanged; new duty from the next counter = 0. Strobe at counter = 999 → applies one period later. upd_ack follows each strobe by exactly 1 cycle.
- Heartbeat: 10_000 cycles low then 10_000 cycles high, repeating. Forced low in mode 01, and resumes in phase when returning to mode 00.

Source files
------------

// File: rtl/ekf_pwm_dac.sv
// Four-channel PWM output stage: SOC, SOH, fault code and heartbeat, with
// double-buffered duty thresholds that only change on a period boundary.
module ekf_pwm_dac #(
  parameter int unsigned CLK_FREQ     = 20_000_000,
  parameter int unsigned PWM_FREQ     = 20_000,
  parameter int unsigned PWM_RES      = 10,
  parameter int unsigned HEARTBEAT_HZ = 1,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FRAC_BITS    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] soc_in,
  input  logic [DATA_WIDTH-1:0] soh_in,
  input  logic [7:0]            fault_in,
  input  logic [1:0]            mode_in,
  output logic [3:0]            pwm_out,
  output logic                  period_start,
  output logic                  upd_ack
);

  localparam int unsigned PERIOD  = CLK_FREQ / PWM_FREQ;
  localparam int unsigned CNT_W   = $clog2(PERIOD);
  localparam int unsigned HB_HALF = CLK_FREQ / (2 * HEARTBEAT_HZ);
  localparam int unsigned HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
  localparam int unsigned PROD_W  = PWM_RES + CNT_W + 1;
  localparam int unsigned NCH     = 3;

  localparam logic [DATA_WIDTH-1:0] ONE_Q    = DATA_WIDTH'(1) << FRAC_BITS;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [HB_W-1:0]       HB_LAST  = HB_W'(HB_HALF - 1);
  localparam logic [PWM_RES-1:0]    CODE_MID = PWM_RES'(1) << (PWM_RES - 1);

  logic [CNT_W-1:0]            cnt;
  logic [HB_W-1:0]             hb_cnt;
  logic                        hb_level;
  logic [NCH-1:0][PWM_RES-1:0] code_c;
  logic [NCH-1:0][CNT_W-1:0]   thr_c;
  logic [NCH-1:0][CNT_W-1:0]   thr_sh;
  logic [NCH-1:0][CNT_W-1:0]   thr_act;
  logic [1:0]                  mode_sh;
  logic [1:0]                  mode_act;

  // Q16.16 to duty code: negatives clamp to 0, >= 1.0 saturates to full scale.
  function automatic logic [PWM_RES-1:0] to_code(input logic [DATA_WIDTH-1:0] v);
    logic [PWM_RES-1:0] c;
    if (v[DATA_WIDTH-1])
      c = '0;
    else if (v >= ONE_Q)
      c = '1;
    else
      c = v[FRAC_BITS-1 -: PWM_RES];
    return c;
  endfunction

  // Full-width product before the shift so no threshold precision is lost.
  function automatic logic [CNT_W-1:0] to_thr(input logic [PWM_RES-1:0] code);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(code) * PROD_W'(PERIOD);
    return CNT_W'(prod >> PWM_RES);
  endfunction

  // Duty codes with mode override, converted to thresholds at capture time.
  always_comb begin
    code_c[0] = to_code(soc_in);
    code_c[1] = to_code(soh_in);
    code_c[2] = PWM_RES'({fault_in, 2'b00});
    if (mode_in[0]) begin
      code_c = '0;
    end else if (mode_in[1]) begin
      for (int unsigned ch = 0; ch < NCH; ch++) code_c[ch] = CODE_MID;
    end
    for (int unsigned ch = 0; ch < NCH; ch++) thr_c[ch] = to_thr(code_c[ch]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (cnt == CNT_LAST)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt   <= '0;
      hb_level <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt   <= '0;
      hb_level <= ~hb_level;
    end else begin
      hb_cnt   <= hb_cnt + HB_W'(1);
    end
  end

  // Shadow capture on strobe; last strobe wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_sh  <= '0;
      mode_sh <= 2'b00;
    end else if (upd_valid) begin
      thr_sh  <= thr_c;
      mode_sh <= mode_in;
    end
  end

  // Active set swaps only on the last count so a period never changes mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_act  <= '0;
      mode_act <= 2'b00;
    end else if (cnt == CNT_LAST) begin
      thr_act  <= thr_sh;
      mode_act <= mode_sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
      upd_ack      <= 1'b0;
    end else begin
      for (int unsigned ch = 0; ch < NCH; ch++) pwm_out[ch] <= (cnt < thr_act[ch]);
      pwm_out[3]   <= hb_level & ~mode_act[0];
      period_start <= (cnt == '0);
      upd_ack      <= upd_valid;
    end
  end

endmodule

// File: tb/tb_ekf_pwm_dac.sv
// Directed bench for ekf_pwm_dac at PERIOD = 1000, heartbeat half-period 10000.
module tb_ekf_pwm_dac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic [31:0] soc_in;
  logic [31:0] soh_in;
  logic [7:0]  fault_in;
  logic [1:0]  mode_in;
  logic [3:0]  pwm_out;
  logic        period_start;
  logic        upd_ack;

  int n_pass  = 0;
  int n_total = 0;
  int edges;
  bit cur_forced;

  typedef struct {
    logic [31:0] soc;
    logic [31:0] soh;
    logic [7:0]  fault;
    logic [1:0]  mode;
    int          e0;
    int          e1;
    int          e2;
  } vec_t;

  vec_t vecs[8];

  ekf_pwm_dac #(
    .CLK_FREQ(20_000), .PWM_FREQ(20), .PWM_RES(10),
    .HEARTBEAT_HZ(1), .DATA_WIDTH(32), .FRAC_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid),
    .soc_in(soc_in), .soh_in(soh_in), .fault_in(fault_in), .mode_in(mode_in),
    .pwm_out(pwm_out), .period_start(period_start), .upd_ack(upd_ack)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release, used to predict the heartbeat phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic sync_ps();
    for (int k = 0; k < 1001 && !period_start; k++) @(negedge clk);
    check("sync_period_start", int'(period_start), 1);
  endtask

  // Samples one full period starting at a period_start sample, optionally
  // strobing an update at sample inj_k (two back-to-back strobes if n_inj == 2).
  task automatic measure(input string tag, input int inj_k, input int n_inj,
                         input logic [31:0] soc_b, input bit forced,
                         output int h0, output int h1, output int h2);
    int ps_err = 0, ack_err = 0, hb_err = 0, hb_exp;
    bit ack_exp;
    h0 = 0; h1 = 0; h2 = 0;
    for (int k = 0; k < 1000; k++) begin
      if (period_start != (k == 0)) ps_err++;
      ack_exp = (inj_k >= 0) && (k > inj_k) && (k <= inj_k + n_inj);
      if (upd_ack != ack_exp) ack_err++;
      hb_exp = forced ? 0 : (((edges - 1) / 10000) % 2);
      if (int'(pwm_out[3]) != hb_exp) hb_err++;
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      if (inj_k >= 0 && k == inj_k) upd_valid = 1'b1;
      if (inj_k >= 0 && n_inj == 2 && k == inj_k + 1) soc_in = soc_b;
      if (inj_k >= 0 && k == inj_k + n_inj) upd_valid = 1'b0;
      @(negedge clk);
    end
    check({tag, " period_start"}, ps_err, 0);
    check({tag, " upd_ack"}, ack_err, 0);
    check({tag, " heartbeat"}, hb_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, h2, hb_lo, hb_hi, k;

    vecs[0] = '{32'h0000_8000, 32'h0000_0000, 8'h00, 2'b00, 500, 0,   0};
    vecs[1] = '{32'h0001_0000, 32'h0002_0000, 8'h20, 2'b00, 999, 999, 125};
    vecs[2] = '{32'hFFFF_0000, 32'h0000_4000, 8'hFF, 2'b00, 0,   250, 996};
    vecs[3] = '{32'h0000_1000, 32'h0000_0000, 8'h00, 2'b10, 500, 500, 500};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 8'hFF, 2'b01, 0,   0,   0};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_0040, 8'h01, 2'b00, 999, 0,   3};
    vecs[6] = '{32'h0000_8000, 32'h0000_8000, 8'h20, 2'b11, 0,   0,   0};
    vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 8'h00, 2'b00, 0,   999, 0};

    rst_n = 1'b0; upd_valid = 1'b0;
    soc_in = '0; soh_in = '0; fault_in = '0; mode_in = 2'b00;
    repeat (3) @(negedge clk);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset period_start", int'(period_start), 0);
    check("reset upd_ack", int'(upd_ack), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first period_start after release", int'(period_start), 1);

    // Heartbeat: 10000 samples low then 10000 high
    hb_lo = 0; hb_hi = 0;
    for (int j = 0; j < 20000; j++) begin
      if (pwm_out[3]) begin
        if (j < 10000) hb_lo++;
        else           hb_hi++;
      end
      @(negedge clk);
    end
    check("heartbeat low phase highs", hb_lo, 0);
    check("heartbeat high phase highs", hb_hi, 10000);

    sync_ps();
    cur_forced = 1'b0;
    for (int i = 0; i < 8; i++) begin
      soc_in = vecs[i].soc; soh_in = vecs[i].soh;
      fault_in = vecs[i].fault; mode_in = vecs[i].mode;
      measure($sformatf("vec%0d load", i), 0, 1, 32'h0, cur_forced, h0, h1, h2);
      cur_forced = vecs[i].mode[0];
      measure($sformatf("vec%0d run", i), -1, 0, 32'h0, cur_forced, h0, h1, h2);
      check($sformatf("vec%0d ch0 high", i), h0, vecs[i].e0);
      check($sformatf("vec%0d ch1 high", i), h1, vecs[i].e1);
      check($sformatf("vec%0d ch2 high", i), h2, vecs[i].e2);
    end

    // Mid-period update must not disturb the running period
    soc_in = 32'h0000_8000; soh_in = '0; fault_in = '0; mode_in = 2'b00;
    measure("mid setup", 0, 1, 32'h0, 1'b0, h0, h1, h2);
    soc_in = 32'h0000_4000;
    measure("mid strobe", 300, 1, 32'h0, 1'b0, h0, h1, h2);
    check("mid strobe period ch0", h0, 500);
    measure("mid next", -1, 0, 32'h0, 1'b0, h0, h1, h2);
    check("mid next period ch0", h0, 250);

    // Strobe coinciding with the active load is deferred a full period
    soc_in = 32'h0001_0000;
    measure("late strobe", 998, 1, 32'h0, 1'b0, h0, h1, h2);
    check("late strobe period ch0", h0, 250);
    measure("late next", -1, 0, 32'h0, 1'b0, h0, h1, h2);
    check("late next period ch0", h0, 250);
    measure("late applied", -1, 0, 32'h0, 1'b0, h0, h1, h2);
    check("late applied period ch0", h0, 999);

    // Back-to-back strobes: last one wins
    soc_in = 32'h0000_C000;
    measure("b2b strobe", 500, 2, 32'h0000_2000, 1'b0, h0, h1, h2);
    check("b2b strobe period ch0", h0, 999);
    measure("b2b next", -1, 0, 32'h0, 1'b0, h0, h1, h2);
    check("b2b last wins ch0", h0, 125);

    // Asynchronous reset during the heartbeat high phase
    for (k = 0; k < 25000 && !pwm_out[3]; k++) @(negedge clk);
    check("heartbeat high before reset", int'(pwm_out[3]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset pwm_out", int'(pwm_out), 0);
    check("async reset period_start", int'(period_start), 0);
    check("async reset upd_ack", int'(upd_ack), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart period_start", int'(period_start), 1);
    check("restart pwm_out", int'(pwm_out), 0);
    measure("post reset", -1, 0, 32'h0, 1'b0, h0, h1, h2);
    check("post reset ch0 high", h0, 0);
    check("post reset ch1 high", h1, 0);
    check("post reset ch2 high", h2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
